// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with a registered read port, occupancy flags and sticky
// overflow/underflow error flags.
module sync_fifo_core #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Flags decode straight from the registered count so they only change after clk.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A set condition on the same edge as clr_err takes priority.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo_core;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [CW-1:0] count;
    logic          overflow, underflow;

    always #5 clk = ~clk;

    sync_fifo_core #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (D - 2),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain queue plus the expected registered outputs.
    logic [W-1:0] q[$];
    logic [W-1:0] m_data;
    bit           m_valid, m_ovf, m_unf;

    typedef struct {
        bit           w;
        logic [W-1:0] d;
        bit           r;
        bit           c;
        int           cnt;
        bit           v;
        logic [W-1:0] rd;
        bit           ovf;
        bit           unf;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic compare_model();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == D));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= D - 2));
        check("almost_empty", 32'(almost_empty), 32'(n <= 2));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_data", 32'(rd_data), 32'(m_data));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Drive one cycle, advance the model using pre-edge occupancy, compare after the edge.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        bit m_full, m_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        m_full  = (q.size() == D);
        m_empty = (q.size() == 0);
        m_valid = 1'b0;
        if (r && !m_empty) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end
        if (w && !m_full) q.push_back(d);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && m_full) m_ovf = 1'b1;
        if (r && m_empty) m_unf = 1'b1;
        @(posedge clk);
        #1;
        compare_model();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        //          w  data   r  c  cnt v  rd     ovf unf
        tbl[0]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 8'h55, 1, 0, 1, 0, 8'h00, 0, 1};
        tbl[2]  = '{0, 8'h00, 1, 0, 0, 1, 8'h55, 0, 1};
        tbl[3]  = '{0, 8'h00, 0, 1, 0, 0, 8'h55, 0, 0};
        tbl[4]  = '{0, 8'h00, 1, 0, 0, 0, 8'h55, 0, 1};
        tbl[5]  = '{0, 8'h00, 1, 1, 0, 0, 8'h55, 0, 1};
        tbl[6]  = '{0, 8'h00, 0, 1, 0, 0, 8'h55, 0, 0};
        tbl[7]  = '{1, 8'h3C, 0, 0, 1, 0, 8'h55, 0, 0};
        tbl[8]  = '{1, 8'hC3, 0, 0, 2, 0, 8'h55, 0, 0};
        tbl[9]  = '{1, 8'h11, 1, 0, 2, 1, 8'h3C, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 1, 1, 8'hC3, 0, 0};
        tbl[11] = '{0, 8'h00, 1, 0, 0, 1, 8'h11, 0, 0};
        tbl[12] = '{0, 8'h00, 0, 0, 0, 0, 8'h11, 0, 0};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_model();

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(tbl[i].unf));
        end

        // Fill 0x01..0x10, overflow attempt, full with simultaneous wr/rd, then drain
        for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        check("filled_full", 32'(full), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        check("full_wr_rd_count", 32'(count), 32'd15);
        check("full_wr_rd_data", 32'(rd_data), 32'h01);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_data", 32'(rd_data), 32'(i));
        end
        check("drained_empty", 32'(empty), 32'd1);

        // Steady occupancy of 6 with simultaneous traffic across the pointer wrap
        for (int i = 0; i < 6; i++) step(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(8'hA0 + i), 1'b1, 1'b0);
            check("steady_count", 32'(count), 32'd6);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at count 9 with rd_valid high
        for (int i = 0; i < 10; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_reset_count", 32'(count), 32'd9);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_model();
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_reset_unf", 32'(underflow), 32'd1);
        check("post_reset_valid", 32'(rd_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic in phases biased toward filling, draining and balance
        for (int i = 0; i < 3000; i++) begin
            int p_wr;
            int ph;
            ph = (i / 250) % 3;
            p_wr = (ph == 0) ? 80 : ((ph == 1) ? 20 : 50);
            step(($urandom_range(99) < p_wr), W'($urandom),
                 ($urandom_range(99) < (100 - p_wr)), ($urandom_range(31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock synchronous FIFO that serves as the design under test driven and checked by the UVM FIFO environment (sequence/driver/monitor/scoreboard).
- Buffers WIDTH-bit words through a DEPTH-entry circular RAM.
- Provides full/empty, almost-full/almost-empty and occupancy count.
- Provides sticky overflow/underflow error flags that the scoreboard checks.
- Read data is registered, with one-cycle latency.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and at least 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data, sampled when a write is accepted.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - rd_data is 0; rd_valid is 0; overflow and underflow are 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - RAM contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accept: wr_acc = wr_en && !full, evaluated on pre-edge state. On accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en && !empty, evaluated on pre-edge state. On accept, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 in the following cycle. Otherwise rd_valid=0 and rd_data holds its value.
- Latency: data written at edge N is readable at edge N+1 at the earliest; rd_data/rd_valid appear after the accepting edge.
- count update: +1 when wr_acc && !rd_acc; -1 when rd_acc && !wr_acc; unchanged when both or neither accept.
- Simultaneous requests:
  - When full with wr_en and rd_en: the read is accepted, the write is rejected (count goes DEPTH-1), and overflow is set.
  - When empty with wr_en and rd_en: the write is accepted, the read is rejected (count goes 1), and underflow is set.
  - In the partial range both are accepted and count is unchanged.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count; they must be glitch-free relative to clk.
- Error flags:
  - overflow is set on any edge with wr_en && full.
  - underflow is set on any edge with rd_en && empty.
  - Both stay set until clr_err or reset.
  - If clr_err and a set condition coincide, set wins.
- Rejected requests never modify pointers, the RAM, or rd_data.
- A reset asserted mid-transfer discards all contents: the FIFO is empty on the next post-reset cycle and stale data is never presented with rd_valid=1.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, overflow=0, underflow=0.
- Write 0x01..0x10 (16 words), then read 16 -> full=1 after the 16th write; almost_full=1 from count=14; rd_data sequence 0x01..0x10, each with a one-cycle rd_valid; empty=1 at end.
- When full, assert wr_en with 0xAA -> count stays 16, overflow=1, and 0xAA never appears on reads. Pulse clr_err -> overflow=0.
- When empty, assert rd_en and wr_en together with 0x55 -> underflow=1, count=1, rd_valid=0. Next read returns 0x55.
- Wrap-around: write 10, read 10, write 12, read 12 with continuous simultaneous wr/rd at count=6 -> data order preserved across the pointer wrap; count constant at 6 during simultaneous ops.
- Assert rst_n low mid-stream at count=9 -> all outputs return to reset values immediately without waiting for clk; after release, the first read attempt sets underflow and produces no rd_valid.
